isr_prefetch_queue: RTL

Parametrised successor to the single-word instruction register. It buffers up to DEPTH instruction words fetched from the memory bus and presents the oldest word as the current instruction to the decoder. The decoder advances the queue explicitly, and the controller can flush it on a branch, interrupt or RIT/SVC. It sits between the memory data bus and the decoder, replacing the one-deep register.

---
 rtl/isr_prefetch_queue.sv | 100 ++++++++++
 1 files changed

// File: rtl/isr_prefetch_queue.sv
// Instruction prefetch queue: buffers up to DEPTH fetched words and presents
// the oldest one to the decoder as the current instruction.
module isr_prefetch_queue #(
    parameter int WIDTH         = 16,
    parameter int DEPTH         = 4,
    parameter int FLUSH_KEEP_IN = 0,
    localparam int CW           = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [WIDTH-1:0] m_bus,
    input  logic             MIS,
    input  logic             ADV,
    input  logic             FLUSH,
    output logic [WIDTH-1:0] ISR,
    output logic             ISR_valid,
    output logic [CW-1:0]    count,
    output logic             full,
    output logic             FETCH_REQ,
    output logic             OVF
);

    localparam int PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PW-1:0]    wp_q, wp_d;
    logic [PW-1:0]    rp_q, rp_d;
    logic [CW-1:0]    count_q, count_d;
    logic             ovf_q, ovf_d;

    logic full_w;
    logic pop;
    logic push;

    assign full_w = (count_q == CW'(DEPTH));
    assign pop    = ADV && (count_q != '0);
    assign push   = MIS && (!full_w || pop);

    always_comb begin
        mem_d   = mem_q;
        wp_d    = wp_q;
        rp_d    = rp_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (FLUSH) begin
            // Queue becomes empty at the current write slot; a branch-target
            // word arriving now can become the new head straight away.
            rp_d    = wp_q;
            count_d = '0;
            if ((FLUSH_KEEP_IN != 0) && MIS) begin
                mem_d[wp_q] = m_bus;
                wp_d        = wp_q + PW'(1);
                count_d     = CW'(1);
            end
        end else begin
            if (push) begin
                mem_d[wp_q] = m_bus;
                wp_d        = wp_q + PW'(1);
            end
            if (pop) begin
                rp_d = rp_q + PW'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CW'(1);
            end else if (pop && !push) begin
                count_d = count_q - CW'(1);
            end
            if (MIS && full_w && !pop) begin
                ovf_d = 1'b1;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (CLR) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wp_q    <= '0;
            rp_q    <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            mem_q   <= mem_d;
            wp_q    <= wp_d;
            rp_q    <= rp_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign ISR       = mem_q[rp_q];
    assign ISR_valid = (count_q != '0);
    assign count     = count_q;
    assign full      = full_w;
    assign FETCH_REQ = !full_w;
    assign OVF       = ovf_q;

endmodule
